// File: rtl/ca_code_correlator.sv
// Early/prompt/late C/A code correlator: integrates sign-corrected samples at three
// chip lags from epoch to epoch and dumps the sums through sticky saturating accumulators.
module ca_code_correlator #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 16,
    parameter int CODE_LEN = 1023
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       chip_valid,
    input  logic                       chip,
    input  logic                       epoch,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    acc_e,
    output logic signed [ACC_W-1:0]    acc_p,
    output logic signed [ACC_W-1:0]    acc_l,
    output logic                       dump_valid,
    output logic                       len_err,
    output logic [9:0]                 chip_count
);

    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [9:0]              COUNT_MAX = 10'd1023;
    localparam logic [9:0]              LEN_EXP   = 10'(CODE_LEN);

    logic                    d1;
    logic                    d2;
    logic                    armed;
    logic [2:0]              lag;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] prod     [3];
    logic signed [ACC_W-1:0] sum_q    [3];
    logic signed [ACC_W-1:0] sum_next [3];
    logic [ACC_W:0]          wide     [3];
    logic [2:0]              stuck_q;
    logic [2:0]              stuck_next;

    // Lane 0 = early (current chip), 1 = prompt (d1), 2 = late (d2)
    assign lag        = {d2, d1, chip};
    assign sample_ext = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};

    // Sign-extended before negation so the most negative sample flips cleanly;
    // once a lane clips it holds its bound until the next epoch restart.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod[i]       = lag[i] ? -sample_ext : sample_ext;
            wide[i]       = {sum_q[i][ACC_W-1], sum_q[i]} + {prod[i][ACC_W-1], prod[i]};
            stuck_next[i] = stuck_q[i];
            sum_next[i]   = sum_q[i];
            if (!stuck_q[i]) begin
                if (wide[i][ACC_W] != wide[i][ACC_W-1]) begin
                    stuck_next[i] = 1'b1;
                    sum_next[i]   = wide[i][ACC_W] ? ACC_MIN : ACC_MAX;
                end else begin
                    sum_next[i] = wide[i][ACC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1         <= 1'b0;
            d2         <= 1'b0;
            armed      <= 1'b0;
            acc_e      <= '0;
            acc_p      <= '0;
            acc_l      <= '0;
            dump_valid <= 1'b0;
            len_err    <= 1'b0;
            chip_count <= '0;
            stuck_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            dump_valid <= 1'b0;
            len_err    <= 1'b0;
            if (chip_valid) begin
                d1 <= chip;
                d2 <= d1;
                if (epoch) begin
                    // The first epoch only aligns the period; pre-epoch sums are dropped
                    if (armed) begin
                        acc_e      <= sum_q[0];
                        acc_p      <= sum_q[1];
                        acc_l      <= sum_q[2];
                        dump_valid <= 1'b1;
                        len_err    <= (chip_count != LEN_EXP);
                    end
                    armed      <= 1'b1;
                    chip_count <= 10'd1;
                    stuck_q    <= '0;
                    for (int i = 0; i < 3; i++) begin
                        sum_q[i] <= prod[i];
                    end
                end else begin
                    stuck_q <= stuck_next;
                    for (int i = 0; i < 3; i++) begin
                        sum_q[i] <= sum_next[i];
                    end
                    if (chip_count != COUNT_MAX) begin
                        chip_count <= chip_count + 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ca_code_correlator.sv
// Bench for ca_code_correlator: 16-bit and 8-bit accumulator instances share stimulus
// and are compared every cycle against a period-level reference model.
module tb_ca_code_correlator;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    chip_valid;
    logic                    chip;
    logic                    epoch;
    logic signed [3:0]       sample;
    logic signed [15:0]      acc_e16, acc_p16, acc_l16;
    logic signed [7:0]       acc_e8, acc_p8, acc_l8;
    logic                    dump16, len16, dump8, len8;
    logic [9:0]              count16, count8;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Reference model state: beats of the open period and expected outputs
    int q_s[$];
    bit q_e[$];
    bit q_p[$];
    bit q_l[$];
    int m16[3];
    int m8[3];
    bit m_dump, m_len, m_armed, h1, h2;
    int m_cnt;

    ca_code_correlator #(.SAMPLE_W(4), .ACC_W(16), .CODE_LEN(1023)) dut16 (
        .clk(clk), .reset_n(reset_n), .chip_valid(chip_valid), .chip(chip),
        .epoch(epoch), .sample(sample), .acc_e(acc_e16), .acc_p(acc_p16),
        .acc_l(acc_l16), .dump_valid(dump16), .len_err(len16), .chip_count(count16)
    );

    ca_code_correlator #(.SAMPLE_W(4), .ACC_W(8), .CODE_LEN(1023)) dut8 (
        .clk(clk), .reset_n(reset_n), .chip_valid(chip_valid), .chip(chip),
        .epoch(epoch), .sample(sample), .acc_e(acc_e8), .acc_p(acc_p8),
        .acc_l(acc_l8), .dump_valid(dump8), .len_err(len8), .chip_count(count8)
    );

    always #5 clk = ~clk;

    function automatic int fold(input int width, input int lane);
        int lo = -(1 << (width - 1));
        int hi = (1 << (width - 1)) - 1;
        int s = 0;
        bit stuck = 0;
        bit c;
        for (int i = 0; i < q_s.size(); i++) begin
            c = (lane == 0) ? q_e[i] : (lane == 1) ? q_p[i] : q_l[i];
            if (!stuck) begin
                s += c ? -q_s[i] : q_s[i];
                if (s > hi) begin
                    s = hi;
                    stuck = 1;
                end else if (s < lo) begin
                    s = lo;
                    stuck = 1;
                end
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        q_s.delete(); q_e.delete(); q_p.delete(); q_l.delete();
        for (int k = 0; k < 3; k++) begin
            m16[k] = 0;
            m8[k]  = 0;
        end
        m_dump = 0; m_len = 0; m_armed = 0; h1 = 0; h2 = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit v, input bit c, input bit e, input int s);
        m_dump = 0;
        m_len  = 0;
        if (v) begin
            if (e) begin
                if (m_armed) begin
                    for (int k = 0; k < 3; k++) begin
                        m16[k] = fold(16, k);
                        m8[k]  = fold(8, k);
                    end
                    m_dump = 1;
                    m_len  = (m_cnt != 1023);
                end
                m_armed = 1;
                m_cnt   = 1;
                q_s.delete(); q_e.delete(); q_p.delete(); q_l.delete();
            end else begin
                m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
            end
            q_s.push_back(s);
            q_e.push_back(c);
            q_p.push_back(h1);
            q_l.push_back(h2);
            h2 = h1;
            h1 = c;
        end
    endtask

    task automatic check_output(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One beat: drive just after a rising edge, let the model see the same edge
    task automatic apply_stimulus(input bit v, input bit c, input bit e, input int s);
        chip_valid = v;
        chip       = c;
        epoch      = e;
        sample     = 4'(s);
        @(posedge clk);
        model_step(v, c, e, s);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(0, 1'($urandom), 1'($urandom), $urandom_range(0, 15) - 8);
    endtask

    // Non-epoch beats 1..n of a period; kind 0 constant, 1 toggling chip, 2 random
    task automatic body(input int n, input int kind, input bit c0, input int s0, input int gap);
        bit c;
        int s;
        for (int i = 1; i <= n; i++) begin
            c = c0;
            s = s0;
            if (kind == 1) c = c0 ^ 1'(i % 2);
            if (kind == 2) begin
                c = 1'($urandom);
                s = $urandom_range(0, 15) - 8;
            end
            apply_stimulus(1, c, 0, s);
            if (gap > 0 && i % gap == 0)
                repeat (3) idle();
            if (kind == 2 && $urandom_range(0, 9) == 0)
                idle();
        end
    endtask

    task automatic apply_reset();
        reset_n = 0;
        model_reset();
        #1;
        check_output("reset_acc_e16", acc_e16, 0);
        check_output("reset_acc_l8", acc_l8, 0);
        check_output("reset_count16", count16, 0);
        check_output("reset_dump16", dump16, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("acc_e16", acc_e16, m16[0]);
            check_output("acc_p16", acc_p16, m16[1]);
            check_output("acc_l16", acc_l16, m16[2]);
            check_output("acc_e8", acc_e8, m8[0]);
            check_output("acc_p8", acc_p8, m8[1]);
            check_output("acc_l8", acc_l8, m8[2]);
            check_output("dump16", dump16, int'(m_dump));
            check_output("len16", len16, int'(m_len));
            check_output("dump8", dump8, int'(m_dump));
            check_output("len8", len8, int'(m_len));
            check_output("count16", count16, m_cnt);
            check_output("count8", count8, m_cnt);
        end
    end

    initial begin
        int len;
        reset_n = 0; chip_valid = 0; chip = 0; epoch = 0; sample = 0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();
        cmp_en = 1;

        // Constant +3 over a full period, then constant chip 1
        apply_stimulus(1, 0, 1, 3);
        check_output("first_epoch_no_dump", dump16, 0);
        body(1022, 0, 0, 3, 0);
        apply_stimulus(1, 1, 1, 3);
        check_output("p1_dump", dump16, 1);
        check_output("p1_len_err", len16, 0);
        check_output("p1_acc_e", acc_e16, 3069);
        check_output("p1_acc_p", acc_p16, 3069);
        check_output("p1_acc_l", acc_l16, 3069);
        check_output("p1_acc_p8_sat", acc_p8, 127);
        body(1022, 0, 1, 3, 0);
        apply_stimulus(1, 0, 1, 1);
        check_output("p2_acc_e", acc_e16, -3069);
        check_output("p2_acc_p", acc_p16, -3063);
        check_output("p2_acc_l", acc_l16, -3057);
        body(1022, 1, 0, 1, 0);
        apply_stimulus(1, 0, 1, 7);
        check_output("toggle_acc_e", acc_e16, 1);
        check_output("toggle_acc_p", acc_p16, -1);
        check_output("toggle_acc_l", acc_l16, -1);

        // Saturation on the 8-bit instance, including the most negative sample
        body(1022, 0, 0, 7, 0);
        apply_stimulus(1, 1, 1, -8);
        check_output("sat_pos_acc_e8", acc_e8, 127);
        check_output("sat_pos_acc_p8", acc_p8, 127);
        body(1022, 0, 1, -8, 0);
        apply_stimulus(1, 0, 1, -8);
        check_output("neg8_flip_acc_e8", acc_e8, 127);
        check_output("neg8_flip_acc_e16", acc_e16, 8184);
        body(1022, 0, 0, -8, 0);
        apply_stimulus(1, 0, 1, 7);
        check_output("sat_neg_acc_e8", acc_e8, -128);
        check_output("sat_neg_acc_e16", acc_e16, -8184);
        body(39, 0, 0, 7, 0);
        body(10, 0, 0, -8, 0);

        // Short periods with idle gaps mid-period
        apply_stimulus(1, 0, 1, -5);
        check_output("sticky_acc_e8", acc_e8, 127);
        check_output("short_len_err8", len8, 1);
        body(499, 0, 0, -5, 100);
        apply_stimulus(1, 1, 1, 2);
        check_output("p500_dump", dump16, 1);
        check_output("p500_len_err", len16, 1);
        check_output("p500_acc_e", acc_e16, -2500);
        idle();
        check_output("dump_clears", dump16, 0);

        // Reset in the middle of a period
        body(200, 2, 0, 0, 0);
        apply_reset();
        apply_stimulus(1, 0, 1, 3);
        check_output("epoch_after_reset_no_dump", dump16, 0);
        body(300, 2, 0, 0, 0);

        // Random periods, then back-to-back epochs
        for (int k = 0; k < 4; k++) begin
            len = (k == 0) ? 1023 : $urandom_range(2, 1023);
            apply_stimulus(1, 1'($urandom), 1, $urandom_range(0, 15) - 8);
            body(len - 1, 2, 0, 0, 0);
        end
        apply_stimulus(1, 0, 1, 4);
        apply_stimulus(1, 1, 1, 5);
        check_output("one_chip_period_len_err", len16, 1);
        check_output("one_chip_period_acc_e", acc_e16, 4);
        repeat (4) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
